pwl_alu_scheduler: RTL and testbench

//   Per-sample sequencer for the shared microcoded ALU (mc_alu) of the 4-channel PWL synth.
//   On each sample tick it issues one oscillator-update op per enabled channel.
//   It then issues the sweep0/sweep1 update ops that are due for this frame.
//   Ops go to the ALU over a valid/ready handshake; the block also flags overrun
//   (a tick arriving while a frame is still in flight).

---
 rtl/pwl_alu_scheduler.sv | 153 +++++++++++++++
 tb/tb_pwl_alu_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pwl_alu_scheduler.sv
// Per-sample sequencer for the shared PWL ALU: one OSC op per enabled channel, then due sweep ops.
// All outputs are registered; they are computed from the next-state values.
module pwl_alu_scheduler #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned RATE_BITS = 4,
  parameter int unsigned CNT_BITS  = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_tick,
  input  logic [NUM_CH-1:0]             chan_en,
  input  logic [NUM_CH*RATE_BITS-1:0]   sweep0_rate,
  input  logic [NUM_CH*RATE_BITS-1:0]   sweep1_rate,
  output logic                          op_valid,
  input  logic                          op_ready,
  output logic [$clog2(NUM_CH)-1:0]     op_chan,
  output logic [1:0]                    op_kind,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun
);

  localparam int unsigned ChW      = $clog2(NUM_CH);
  localparam int unsigned NumSweep = 2 * NUM_CH;
  localparam int unsigned SlotW    = $clog2(NumSweep);

  typedef enum logic [1:0] {StIdle, StOsc, StSweep, StDone} state_e;

  state_e              state_q, state_d;
  logic [SlotW-1:0]    slot_q, slot_d;
  logic [NUM_CH-1:0]   en_lat_q, en_lat_d;
  logic [NumSweep-1:0] pend_q, pend_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [NumSweep-1:0] due;

  logic                op_valid_d;
  logic [ChW-1:0]      op_chan_d;
  logic [1:0]          op_kind_d;
  logic                busy_d, frame_done_d, overrun_d;

  // Rate r fires when the low r bits of the frame count are zero; all-ones rate is off.
  function automatic logic rate_due(input logic [RATE_BITS-1:0] rate,
                                    input logic [CNT_BITS-1:0]  cnt);
    logic [CNT_BITS-1:0] mask;
    mask = (CNT_BITS'(1) << rate) - CNT_BITS'(1);
    return (rate != '1) && ((cnt & mask) == '0);
  endfunction

  always_comb begin
    due = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      due[2*c]   = rate_due(sweep0_rate[c*RATE_BITS +: RATE_BITS], cnt_q);
      due[2*c+1] = rate_due(sweep1_rate[c*RATE_BITS +: RATE_BITS], cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      slot_q     <= '0;
      en_lat_q   <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      op_valid   <= 1'b0;
      op_chan    <= '0;
      op_kind    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      en_lat_q   <= en_lat_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      op_valid   <= op_valid_d;
      op_chan    <= op_chan_d;
      op_kind    <= op_kind_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      overrun    <= overrun_d;
    end
  end

  // op_valid always reflects the current slot, so a slot advances on accept or when idle.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    en_lat_d = en_lat_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sample_tick) begin
          en_lat_d = chan_en;
          pend_d   = due;
          cnt_d    = cnt_q + CNT_BITS'(1);
          slot_d   = '0;
          state_d  = StOsc;
        end
      end
      StOsc: begin
        if (!op_valid || op_ready) begin
          if (slot_q == SlotW'(NUM_CH - 1)) begin
            slot_d  = '0;
            state_d = StSweep;
          end else begin
            slot_d = slot_q + SlotW'(1);
          end
        end
      end
      StSweep: begin
        if (!op_valid || op_ready) begin
          if (op_valid) pend_d[slot_q] = 1'b0;
          if (slot_q == SlotW'(NumSweep - 1)) begin
            slot_d  = '0;
            state_d = StDone;
          end else begin
            slot_d = slot_q + SlotW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_valid_d = 1'b0;
    op_chan_d  = '0;
    op_kind_d  = '0;
    unique case (state_d)
      StOsc: begin
        op_chan_d  = slot_d[ChW-1:0];
        op_valid_d = en_lat_d[op_chan_d];
      end
      StSweep: begin
        op_chan_d  = slot_d[SlotW-1:1];
        op_kind_d  = {slot_d[0], ~slot_d[0]};
        op_valid_d = pend_d[slot_d] && en_lat_d[op_chan_d];
      end
      default: ;
    endcase
    if (!op_valid_d) begin
      op_chan_d = '0;
      op_kind_d = '0;
    end
    busy_d       = (state_d != StIdle);
    frame_done_d = (state_d == StDone);
    overrun_d    = sample_tick && (state_q != StIdle);
  end

endmodule

// File: tb/tb_pwl_alu_scheduler.sv
// Directed bench for pwl_alu_scheduler: frame timing, enables, sweep cadence, stalls,
// dropped ticks and mid-frame reset, with hand-derived expectations.
module tb_pwl_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic [3:0]  chan_en;
  logic [15:0] sweep0_rate, sweep1_rate;
  logic        op_valid, op_ready;
  logic [1:0]  op_chan, op_kind;
  logic        busy, frame_done, overrun;

  int total = 0;
  int bad   = 0;

  int ops_chan [64];
  int ops_kind [64];
  int ops_cyc  [64];
  int n_ops, done_cyc, held, ovr_cnt, busy_after;

  always #5 clk = ~clk;

  pwl_alu_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .chan_en     (chan_en),
    .sweep0_rate (sweep0_rate),
    .sweep1_rate (sweep1_rate),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_chan     (op_chan),
    .op_kind     (op_kind),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Enter and leave at a falling edge.
  task automatic do_reset();
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    op_ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycle k=1 is the cycle after the tick; ticks repeat at k==t1/t2, op_ready low for k<=stall.
  task automatic run_frame(input int stall, input int t1, input int t2);
    n_ops = 0; done_cyc = -1; held = 0; ovr_cnt = 0; busy_after = -1;
    sample_tick = 1'b1;
    op_ready    = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 80; k++) begin
      sample_tick = (k == t1) || (k == t2);
      op_ready    = (k > stall);
      if (overrun) ovr_cnt++;
      if (op_valid && !op_ready && op_chan == 2'd0 && op_kind == 2'd0) held++;
      if (op_valid && op_ready && n_ops < 64) begin
        ops_chan[n_ops] = int'(op_chan);
        ops_kind[n_ops] = int'(op_kind);
        ops_cyc[n_ops]  = k;
        n_ops++;
      end
      if (frame_done && done_cyc < 0) done_cyc = k;
      if (done_cyc >= 0 && k == done_cyc + 1) begin
        busy_after = int'(busy);
        break;
      end
      @(negedge clk);
    end
    sample_tick = 1'b0;
    op_ready    = 1'b1;
    if (done_cyc < 0) check_eq("frame_timeout", 0, 1);
  endtask

  initial begin
    chan_en     = 4'hF;
    sweep0_rate = 16'hFFFF;
    sweep1_rate = 16'hFFFF;
    do_reset();

    check_eq("rst_valid", int'(op_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(frame_done), 0);
    check_eq("rst_ovr", int'(overrun), 0);

    // 1: all channels, no sweeps
    run_frame(0, -1, -1);
    check_eq("t1_nops", n_ops, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_chan", ops_chan[i], i);
      check_eq("t1_kind", ops_kind[i], 0);
      check_eq("t1_cyc", ops_cyc[i], i + 1);
    end
    check_eq("t1_done", done_cyc, 13);
    check_eq("t1_busy_after", busy_after, 0);

    // 2: sparse enables
    chan_en = 4'b0101;
    run_frame(0, -1, -1);
    check_eq("t2_nops", n_ops, 2);
    check_eq("t2_ch_a", ops_chan[0], 0);
    check_eq("t2_cyc_a", ops_cyc[0], 1);
    check_eq("t2_ch_b", ops_chan[1], 2);
    check_eq("t2_cyc_b", ops_cyc[1], 3);
    check_eq("t2_done", done_cyc, 13);

    // 4: five-cycle stall on the first OSC op
    chan_en = 4'hF;
    run_frame(5, -1, -1);
    check_eq("t4_held", held, 5);
    check_eq("t4_nops", n_ops, 4);
    check_eq("t4_first_cyc", ops_cyc[0], 6);
    check_eq("t4_done", done_cyc, 18);

    // 3: sweep0 ch1 every 4 frames, sweep1 ch3 every frame
    do_reset();
    sweep0_rate = 16'hFF2F;
    sweep1_rate = 16'h0FFF;
    for (int f = 0; f < 9; f++) begin
      run_frame(0, -1, -1);
      check_eq("t3_nops", n_ops, (f % 4 == 0) ? 6 : 5);
      if (n_ops > 0) begin
        check_eq("t3_last_kind", ops_kind[n_ops-1], 2);
        check_eq("t3_last_chan", ops_chan[n_ops-1], 3);
        check_eq("t3_last_cyc", ops_cyc[n_ops-1], 12);
      end
      if (f % 4 == 0) begin
        check_eq("t3_s0_op", ops_kind[4] * 4 + ops_chan[4], 5);
        check_eq("t3_s0_cyc", ops_cyc[4], 7);
      end
      check_eq("t3_done", done_cyc, 13);
    end

    // 5: ticks in OSC and DONE are dropped; sweep0 ch0 rate 1 exposes the frame count
    do_reset();
    sweep0_rate = 16'hFFF1;
    sweep1_rate = 16'hFFFF;
    run_frame(0, 2, 13);
    check_eq("t5_ovr", ovr_cnt, 2);
    check_eq("t5_nops_a", n_ops, 5);
    check_eq("t5_done_a", done_cyc, 13);
    check_eq("t5_busy_after", busy_after, 0);
    run_frame(0, -1, -1);
    check_eq("t5_nops_b", n_ops, 4);
    check_eq("t5_ovr_b", ovr_cnt, 0);
    check_eq("t5_done_b", done_cyc, 13);

    // 6: reset while a sweep op is held
    do_reset();
    sweep0_rate = {4'd7, 4'd0, 4'd3, 4'd14};
    sweep1_rate = {4'd15, 4'd1, 4'd14, 4'd5};
    run_frame(0, -1, -1);
    check_eq("t6_nops_f0", n_ops, 11);
    begin
      int found;
      found = 0;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        if (op_valid && op_kind != 2'd0) begin
          op_ready = 1'b0;
          found = 1;
          break;
        end
        @(negedge clk);
      end
      check_eq("t6_sweep_seen", found, 1);
      check_eq("t6_sweep_chan", int'(op_chan), 2);
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", int'(op_valid), 0);
    check_eq("t6_rst_busy", int'(busy), 0);
    check_eq("t6_rst_kind", int'(op_kind), 0);
    check_eq("t6_rst_chan", int'(op_chan), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    op_ready = 1'b1;
    @(negedge clk);
    run_frame(0, -1, -1);
    check_eq("t6_nops_after", n_ops, 11);
    check_eq("t6_done_after", done_cyc, 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
